// File: rtl/uart_port_rx_pkg.sv
// rtl/uart_port_rx_pkg.sv - shared receive-FSM state encodings and frame constants
package uart_port_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_port_rx_if.sv
// rtl/uart_port_rx_if.sv - byte handshake between the UART receiver and its consumer
interface uart_port_rx_if;

  logic       port_write;
  logic [7:0] port_in;
  logic       port_ready;

  modport master (output port_write, output port_in, input port_ready);
  modport slave  (input port_write, input port_in, output port_ready);

endinterface

// File: rtl/uart_port_rx_sync_fifo.sv
// rtl/uart_port_rx_sync_fifo.sv - small synchronous FIFO with a registered head word
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head only moves on a pop, or when a byte lands in an empty slot at the head.
      if (do_push && (empty || (do_pop && count == CW'(1))))
        head <= push_data;
      else if (do_pop && count > CW'(1))
        head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/uart_port_rx.sv
// rtl/uart_port_rx.sv - 8N1 UART receiver feeding a byte FIFO onto the port_in/port_write pair
module uart_port_rx
  import uart_port_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rxd,
  input  logic                        err_clear,
  uart_port_rx_if.master              rx_port,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  rx_state_t     state;
  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic [BW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          half_bit;
  logic          full_bit;
  logic          push;
  logic          stop_bad;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;

  assign rx_s     = sync[1];
  assign half_bit = (cnt == BW'(CLKS_PER_BIT/2 - 1));
  assign full_bit = (cnt == BW'(CLKS_PER_BIT - 1));
  assign push     = (state == STOP) && full_bit && rx_s;
  assign stop_bad = (state == STOP) && full_bit && !rx_s;
  assign pop      = rx_port.port_write && rx_port.port_ready;
  assign drop     = push && fifo_full && !pop;

  assign rx_port.port_write = !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rxd};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (stop_bad)       frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (drop)           overflow  <= 1'b1;
      else if (err_clear) overflow  <= 1'b0;

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) state <= START;
        end
        START: begin
          if (half_bit) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (full_bit) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (full_bit) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (rx_port.port_in)
  );

endmodule

// File: tb/tb_uart_port_rx.sv
// tb/tb_uart_port_rx.sv - directed bench for uart_port_rx
module tb_uart_port_rx;
  import uart_port_rx_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       err_clear = 1'b0;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base;
  logic [7:0] got_data [$];
  int         got_cyc  [$];

  uart_port_rx_if u_if ();

  uart_port_rx #(
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .err_clear  (err_clear),
    .rx_port    (u_if.master),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset && u_if.port_write && u_if.port_ready) begin
      got_data.push_back(u_if.port_in);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low = 0);
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(16);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      tick(16 * stop_low);
    end
    rxd = 1'b1;
    tick(16);
  endtask

  initial begin
    u_if.port_ready = 1'b1;
    tick(3);
    reset = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("reset_idle", {20'd0, u_if.port_write, u_if.port_in, fifo_count, frame_err, overflow}, 32'd0);
    end

    // two back-to-back frames, consumer always ready
    tick(1);
    base = got_data.size();
    send_byte(8'h55);
    send_byte(8'hA3);
    tick(4);
    check("two_count", got_data.size(), base + 2);
    if (got_data.size() >= base + 2) begin
      check("two_first", got_data[base], 8'h55);
      check("two_second", got_data[base+1], 8'hA3);
      check("two_gap", got_cyc[base+1] - got_cyc[base], 160);
    end
    check("two_idle_write", u_if.port_write, 1'b0);
    check("two_flags", {frame_err, overflow}, 2'b00);

    // five bytes into a four-deep FIFO with the consumer stalled
    u_if.port_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_byte(8'(k));
    tick(4);
    check("ovf_count", fifo_count, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head_write", u_if.port_write, 1'b1);
    check("ovf_head_data", u_if.port_in, 8'h01);
    base = got_data.size();
    u_if.port_ready = 1'b1;
    tick(6);
    check("drain_count", got_data.size(), base + 4);
    if (got_data.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        check("drain_data", got_data[base+k], k + 1);
        if (k > 0) check("drain_back_to_back", got_cyc[base+k] - got_cyc[base+k-1], 1);
      end
    end
    check("drain_write", u_if.port_write, 1'b0);
    check("drain_fifo_count", fifo_count, 3'd0);
    check("ovf_sticky", overflow, 1'b1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // stop bit held low for three bit times
    base = got_data.size();
    send_byte(8'h7E, 3);
    tick(4);
    check("ferr_no_push", got_data.size(), base);
    check("ferr_flag", frame_err, 1'b1);
    check("ferr_fifo_count", fifo_count, 3'd0);
    send_byte(8'h42);
    tick(4);
    check("after_ferr_count", got_data.size(), base + 1);
    if (got_data.size() >= base + 1) check("after_ferr_data", got_data[base], 8'h42);
    check("ferr_sticky", frame_err, 1'b1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ferr_cleared", frame_err, 1'b0);

    // short low glitch while idle
    base = got_data.size();
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    check("glitch_no_push", got_data.size(), base);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_flags", {frame_err, overflow}, 2'b00);

    // reset in the middle of data bit 4 with one byte already buffered
    u_if.port_ready = 1'b0;
    send_byte(8'h11);
    tick(4);
    check("pre_reset_count", fifo_count, 3'd1);
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'(8'hB5 >> i);
      tick(16);
    end
    rxd = 1'b1;
    tick(8);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_count", fifo_count, 3'd0);
    check("post_reset_write", u_if.port_write, 1'b0);
    check("post_reset_data", u_if.port_in, 8'h00);
    tick(40);
    u_if.port_ready = 1'b1;
    tick(2);
    base = got_data.size();
    send_byte(8'h9C);
    tick(4);
    check("post_reset_rx_count", got_data.size(), base + 1);
    if (got_data.size() >= base + 1) check("post_reset_rx_data", got_data[base], 8'h9C);
    check("post_reset_flags", {frame_err, overflow}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
